// File: rtl/temp_log_sink.sv
// Timestamped temperature logger: accepts UART temperature bytes, stores them with the
// current clock time in a FIFO, counts parity errors and drives a hysteresis alarm.
module temp_log_sink #(
  parameter int          DEPTH      = 16,
  parameter logic [7:0]  HIGH_LIMIT = 8'd80,
  parameter logic [7:0]  LOW_LIMIT  = 8'd70
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     parity_error,
  input  logic [5:0]               seconds,
  input  logic [5:0]               minuits,
  input  logic [4:0]               hours,
  input  logic [4:0]               days,
  input  logic [3:0]               months,
  input  logic                     rd_en,
  output logic [33:0]              rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               err_count,
  output logic                     alarm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {NORMAL, HOT} state_t;

  logic [33:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [33:0]   r_rd_data_p1;
  logic          r_rd_vld_p1;
  logic          r_overflow;
  logic [7:0]    r_err_count;
  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_accept;
  logic          w_full;
  logic          w_empty;
  logic          w_rd_fire;
  logic          w_wr_fire;
  logic [33:0]   w_record;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_accept  = rx_valid & ~parity_error;
  assign w_rd_fire = rd_en & ~w_empty;
  // A full FIFO still takes the write when a read frees the slot in the same cycle.
  assign w_wr_fire = w_accept & (~w_full | w_rd_fire);
  assign w_record  = {months, days, hours, minuits, seconds, rx_data};

  // Storage: data only, no reset
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wptr] <= w_record;
    end
  end

  // Control and read stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_rd_data_p1 <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_overflow   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_rd_vld_p1 <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data_p1 <= r_mem[r_rptr];
        r_rptr       <= r_rptr + AW'(1);
      end
      if (w_wr_fire) begin
        r_wptr <= r_wptr + AW'(1);
      end
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && w_full && !rd_en) begin
        r_overflow <= 1'b1;
      end
      if (rx_valid && parity_error && r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Alarm hysteresis sees every accepted byte, stored or dropped.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        NORMAL:  if (rx_data > HIGH_LIMIT) w_state_nxt = HOT;
        HOT:     if (rx_data < LOW_LIMIT)  w_state_nxt = NORMAL;
        default: w_state_nxt = NORMAL;
      endcase
    end
  end

  assign rd_data   = r_rd_data_p1;
  assign rd_valid  = r_rd_vld_p1;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign err_count = r_err_count;
  assign alarm     = (r_state == HOT);

endmodule

// File: tb/tb_temp_log_sink.sv
// Self-checking bench for temp_log_sink: vector tables plus a scoreboard queue of
// expected FIFO records.
module tb_temp_log_sink;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        parity_error;
  logic [5:0]  seconds;
  logic [5:0]  minuits;
  logic [4:0]  hours;
  logic [4:0]  days;
  logic [3:0]  months;
  logic        rd_en;
  logic [33:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  err_count;
  logic        alarm;

  temp_log_sink dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_error(parity_error), .seconds(seconds), .minuits(minuits),
    .hours(hours), .days(days), .months(months), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .err_count(err_count), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] temp;
    logic [5:0] sec;
    logic [5:0] mn;
    logic [4:0] hr;
    logic [4:0] dy;
    logic [3:0] mo;
  } wr_vec_t;

  typedef struct {
    logic [7:0] temp;
    logic       exp_alarm;
  } al_vec_t;

  int          errors;
  int          checks;
  int          m_count;
  logic        m_ovf;
  logic [33:0] exp_q [$];
  logic [33:0] last_rd;
  wr_vec_t     wtbl [17];
  al_vec_t     atbl [8];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] pack(input wr_vec_t v);
    return {v.mo, v.dy, v.hr, v.mn, v.sec, v.temp};
  endfunction

  task automatic drive_wr(input wr_vec_t v);
    rx_data = v.temp; seconds = v.sec; minuits = v.mn;
    hours = v.hr; days = v.dy; months = v.mo;
    rx_valid = 1'b1; parity_error = 1'b0;
  endtask

  // Single write, no read; the model decides store or drop.
  task automatic wr(input wr_vec_t v);
    drive_wr(v);
    if (m_count < 16) begin
      exp_q.push_back(pack(v));
      m_count++;
    end else begin
      m_ovf = 1'b1;
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic rd(input string name);
    logic [33:0] e;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_count--;
      chk({name, "_vld"}, {33'd0, rd_valid}, 34'd1);
      chk({name, "_data"}, rd_data, e);
      last_rd = e;
    end else begin
      chk({name, "_vld0"}, {33'd0, rd_valid}, 34'd0);
      chk({name, "_hold"}, rd_data, last_rd);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    last_rd = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, {29'd0, count}, 34'd0);
    chk({tag, "_empty"}, {33'd0, empty}, 34'd1);
    chk({tag, "_full"}, {33'd0, full}, 34'd0);
    chk({tag, "_rdvld"}, {33'd0, rd_valid}, 34'd0);
    chk({tag, "_rddata"}, rd_data, 34'd0);
    chk({tag, "_ovf"}, {33'd0, overflow}, 34'd0);
    chk({tag, "_err"}, {26'd0, err_count}, 34'd0);
    chk({tag, "_alarm"}, {33'd0, alarm}, 34'd0);
  endtask

  initial begin
    wr_vec_t v;
    logic [33:0] e;
    errors = 0; checks = 0;
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; parity_error = 1'b0;
    seconds = '0; minuits = '0; hours = '0; days = '0; months = '0; rd_en = 1'b0;

    for (int i = 0; i < 17; i++) begin
      wtbl[i] = '{temp: 8'(8'h10 + i), sec: 6'((i * 7) % 60), mn: 6'((i * 11) % 60),
                  hr: 5'(i % 24), dy: 5'(1 + i), mo: 4'(1 + (i % 12))};
    end
    atbl[0] = '{8'd75, 1'b0}; atbl[1] = '{8'd81, 1'b1};
    atbl[2] = '{8'd72, 1'b1}; atbl[3] = '{8'd69, 1'b0};
    atbl[4] = '{8'd80, 1'b0}; atbl[5] = '{8'd81, 1'b1};
    atbl[6] = '{8'd70, 1'b1}; atbl[7] = '{8'd69, 1'b0};

    tick();
    do_reset();
    chk_reset_state("rst0");

    // Single record with known timestamp
    v = '{temp: 8'h19, sec: 6'd7, mn: 6'd10, hr: 5'd5, dy: 5'd3, mo: 4'd2};
    wr(v);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front(); m_count--;
    chk("single_vld", {33'd0, rd_valid}, 34'd1);
    chk("single_data", rd_data, {4'd2, 5'd3, 5'd5, 6'd10, 6'd7, 8'h19});
    chk("single_model", rd_data, e);
    last_rd = e;
    tick();
    chk("single_vld_drop", {33'd0, rd_valid}, 34'd0);
    chk("single_hold", rd_data, last_rd);

    // Fill to 16
    for (int i = 0; i < 16; i++) begin
      wr(wtbl[i]);
      chk("fill_count", {29'd0, count}, 34'(m_count));
    end
    chk("fill_full", {33'd0, full}, 34'd1);
    chk("fill_ovf0", {33'd0, overflow}, 34'd0);

    // Full: write and read together
    drive_wr(wtbl[16]);
    rd_en = 1'b1;
    e = exp_q.pop_front();
    exp_q.push_back(pack(wtbl[16]));
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    chk("fullrw_vld", {33'd0, rd_valid}, 34'd1);
    chk("fullrw_data", rd_data, e);
    chk("fullrw_count", {29'd0, count}, 34'd16);
    chk("fullrw_ovf", {33'd0, overflow}, 34'd0);
    last_rd = e;

    // Write while full without read is dropped
    wr(wtbl[0]);
    chk("drop_ovf", {33'd0, overflow}, {33'd0, m_ovf});
    chk("drop_count", {29'd0, count}, 34'd16);

    for (int i = 0; i < 16; i++) rd("drain");
    chk("drain_empty", {33'd0, empty}, 34'd1);
    chk("drain_ovf_sticky", {33'd0, overflow}, 34'd1);
    rd("empty_rd");

    // Read of empty FIFO with simultaneous write
    drive_wr(wtbl[3]);
    rd_en = 1'b1;
    exp_q.push_back(pack(wtbl[3])); m_count++;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    chk("emptyrw_vld", {33'd0, rd_valid}, 34'd0);
    chk("emptyrw_count", {29'd0, count}, 34'd1);
    rd("emptyrw_rd");

    // Parity errors: high byte must not touch alarm
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rx_data = 8'd200; rx_valid = 1'b1; parity_error = 1'b1;
      tick();
      if (i == 2) begin
        chk("par3_err", {26'd0, err_count}, 34'd3);
        chk("par3_count", {29'd0, count}, 34'd0);
      end
    end
    rx_valid = 1'b0; parity_error = 1'b0;
    chk("par300_err", {26'd0, err_count}, 34'd255);
    chk("par_alarm", {33'd0, alarm}, 34'd0);
    chk("par_empty", {33'd0, empty}, 34'd1);

    // Alarm hysteresis table
    for (int i = 0; i < 8; i++) begin
      v = wtbl[i];
      v.temp = atbl[i].temp;
      wr(v);
      chk("alarm_tbl", {33'd0, alarm}, {33'd0, atbl[i].exp_alarm});
    end

    // Dropped bytes still drive the alarm
    while (m_count < 16) wr(wtbl[0]);
    v = wtbl[1]; v.temp = 8'd90;
    wr(v);
    chk("dropped_alarm_hot", {33'd0, alarm}, 34'd1);
    chk("dropped_count", {29'd0, count}, 34'd16);
    v.temp = 8'd60;
    wr(v);
    chk("dropped_alarm_cool", {33'd0, alarm}, 34'd0);

    // Reset mid-burst at count 5
    do_reset();
    for (int i = 0; i < 5; i++) wr(wtbl[i]);
    chk("pre_rst_count", {29'd0, count}, 34'd5);
    v = wtbl[5]; v.temp = 8'd95;
    drive_wr(v);
    rd_en = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; rx_valid = 1'b0; rd_en = 1'b0;
    exp_q.delete(); m_count = 0; m_ovf = 1'b0; last_rd = '0;
    chk_reset_state("rst_mid");
    rd("post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temp_log_sink.md
TEMP_LOG_SINK -- requirements
Module: temp_log_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter HIGH_LIMIT, default 8'd80, alarm-set temperature.
REQ-003 SHALL have parameter LOW_LIMIT, default 8'd70, alarm-clear temperature (LOW_LIMIT < HIGH_LIMIT).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx_data, input, 8, temperature byte from the UART receiver.
REQ-007 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port parity_error, input, 1, parity-error flag, valid with rx_valid.
REQ-009 SHALL have ports seconds (6), minuits (6), hours (5), days (5), months (4), input, current digital-clock time.
REQ-010 SHALL have port rd_en, input, 1, read request from the consumer.
REQ-011 SHALL have port rd_data, output, 34, record {months,days,hours,minuits,seconds,temp}.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle strobe qualifying rd_data.
REQ-013 SHALL have ports empty, full, output, 1 each, FIFO status.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, stored-record count.
REQ-015 SHALL have port overflow, output, 1, sticky dropped-record flag.
REQ-016 SHALL have port err_count, output, 8, saturating parity-error counter.
REQ-017 SHALL have port alarm, output, 1, high-temperature alarm.

Function
REQ-018 A byte SHALL be accepted when rx_valid=1 and parity_error=0; timestamp inputs SHALL be sampled in that same cycle.
REQ-019 rx_valid=1 with parity_error=1 SHALL NOT write; err_count SHALL increment, saturating at 255.
REQ-020 Accepted byte with full=1 and rd_en=0 SHALL be dropped and overflow SHALL set; overflow clears only on reset.
REQ-021 Accepted byte with full=1 and rd_en=1 SHALL write and read in the same cycle; count unchanged, overflow unchanged.
REQ-022 rd_en=1 with empty=1 SHALL be ignored; rd_valid stays 0; a simultaneous accepted write SHALL proceed.
REQ-023 Read latency SHALL be one cycle: rd_en in cycle N -> rd_data/rd_valid in N+1, oldest record first (FIFO order).
REQ-024 rd_data SHALL hold its last value while rd_valid=0.
REQ-025 Write and read pointers SHALL wrap modulo DEPTH; count SHALL be registered and range 0..DEPTH.
REQ-026 empty SHALL equal (count==0), full SHALL equal (count==DEPTH), both reflecting the registered count.
REQ-027 Alarm FSM SHALL have states NORMAL and HOT; alarm=1 exactly in HOT.
REQ-028 NORMAL->HOT when an accepted byte is > HIGH_LIMIT (unsigned); HOT->NORMAL when an accepted byte is < LOW_LIMIT; else hold.
REQ-029 Alarm evaluation SHALL use every accepted byte, including bytes dropped for overflow; parity-error bytes SHALL NOT affect it.
REQ-030 alarm SHALL update the cycle after the accepting cycle.

Reset
REQ-031 On reset: pointers=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, err_count=0, FSM=NORMAL, alarm=0.
REQ-032 Reset SHALL dominate rx_valid and rd_en in the same cycle; records in flight SHALL be discarded.

Verification
REQ-033 Write 0x19 at time 05:10:07 day 3 month 2, then rd_en -> next cycle rd_valid=1, rd_data={4'd2,5'd3,5'd5,6'd10,6'd7,8'h19}.
REQ-034 Write 17 bytes (DEPTH=16) without reads -> full=1 after 16, overflow=1 after 17th, reads return first 16 in order.
REQ-035 While full, rx_valid and rd_en in same cycle -> count stays 16, overflow stays 0, oldest record returned.
REQ-036 Three rx_valid with parity_error=1 -> count=0, err_count=3; 300 such strobes -> err_count=255.
REQ-037 Bytes 75, 81, 72, 69 -> alarm 0, 1, 1, 0 (one cycle after each).
REQ-038 Reset asserted mid-burst with FIFO at count=5 -> next cycle all REQ-031 values, subsequent read of empty FIFO gives rd_valid=0.
